fp_rnd: RTL and testbench

FP_RND -- requirements
Module: fp_rnd

---
 rtl/fp_rnd.sv | 186 ++++++++++++++++++
 tb/tb_fp_rnd.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_rnd.sv
// rtl/fp_rnd.sv - two-stage IEEE-754 single/double rounding and result packing
// Optional build macro: FP_RND_NANBOX_EN (NaN-box single results into [63:32]).
module fp_rnd (
   input  logic        clock,
   input  logic        reset,
   input  logic        fp_rnd_i_sig,
   input  logic [13:0] fp_rnd_i_expo,
   input  logic [53:0] fp_rnd_i_mant,
   input  logic [1:0]  fp_rnd_i_rema,
   input  logic [1:0]  fp_rnd_i_fmt,
   input  logic [2:0]  fp_rnd_i_rm,
   input  logic [2:0]  fp_rnd_i_grs,
   input  logic        fp_rnd_i_snan,
   input  logic        fp_rnd_i_qnan,
   input  logic        fp_rnd_i_dbz,
   input  logic        fp_rnd_i_infs,
   input  logic        fp_rnd_i_zero,
   input  logic        fp_rnd_i_diff,
   input  logic        fp_rnd_i_ready,
   input  logic        fp_rnd_i_stall,
   input  logic        fp_rnd_i_flush,
   output logic [63:0] fp_rnd_o_result,
   output logic [4:0]  fp_rnd_o_flags,
   output logic        fp_rnd_o_ready
);

`ifdef FP_RND_NANBOX_EN
   localparam logic [31:0] C_BOX = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] C_BOX = 32'h0000_0000;
`endif

   localparam logic [2:0] C_RNE = 3'd0;
   localparam logic [2:0] C_RTZ = 3'd1;
   localparam logic [2:0] C_RDN = 3'd2;
   localparam logic [2:0] C_RUP = 3'd3;

   // stage 1 state
   logic        r_s1_valid;
   logic        r_s1_sig;
   logic [13:0] r_s1_expo;
   logic [53:0] r_s1_mant;
   logic        r_s1_dbl;
   logic [2:0]  r_s1_rm;
   logic        r_s1_inexact;
   logic        r_s1_snan;
   logic        r_s1_qnan;
   logic        r_s1_dbz;
   logic        r_s1_infs;
   logic        r_s1_zero;
   logic        r_s1_diff;

   // stage 2 state
   logic        r_s2_valid;
   logic [63:0] r_s2_result;
   logic [4:0]  r_s2_flags;

   logic        w_dbl;
   logic [2:0]  w_rm;
   logic        w_inexact;
   logic        w_up;
   logic [53:0] w_mant_sel;
   logic [53:0] w_mant_inc;
   logic        w_unused;

   logic        w_carry;
   logic [53:0] w_mant_n;
   logic [14:0] w_expo_n;
   logic        w_hidden;
   logic        w_ovf;
   logic        w_to_inf;
   logic        w_zsig;
   logic [63:0] w_inf;
   logic [63:0] w_max;
   logic [63:0] w_pk;
   logic [4:0]  w_flags;
   logic [63:0] w_result;

   assign w_unused = ^{fp_rnd_i_rema, fp_rnd_i_mant[53]};

   always_comb begin
      w_dbl      = (fp_rnd_i_fmt == 2'd1);
      w_rm       = (fp_rnd_i_rm > 3'd4) ? C_RNE : fp_rnd_i_rm;
      w_inexact  = |fp_rnd_i_grs;
      w_up       = 1'b0;
      case (w_rm)
         C_RNE:   w_up = fp_rnd_i_grs[2] & (fp_rnd_i_grs[1] | fp_rnd_i_grs[0] | fp_rnd_i_mant[0]);
         C_RTZ:   w_up = 1'b0;
         C_RDN:   w_up = fp_rnd_i_sig & w_inexact;
         C_RUP:   w_up = ~fp_rnd_i_sig & w_inexact;
         default: w_up = fp_rnd_i_grs[2];
      endcase
      w_mant_sel = w_dbl ? {1'b0, fp_rnd_i_mant[52:0]} : {30'd0, fp_rnd_i_mant[23:0]};
      w_mant_inc = w_mant_sel + {53'd0, w_up};
   end

   // stage 2: renormalise after the increment, then pick special/overflow/normal packing
   always_comb begin
      w_carry  = r_s1_dbl ? r_s1_mant[53] : r_s1_mant[24];
      w_mant_n = w_carry ? {1'b0, r_s1_mant[53:1]} : r_s1_mant;
      w_expo_n = {1'b0, r_s1_expo} + {14'd0, w_carry};
      w_hidden = r_s1_dbl ? w_mant_n[52] : w_mant_n[23];
      if ((w_expo_n == 15'd0) && w_hidden) begin
         w_expo_n = 15'd1;
      end
      w_ovf    = r_s1_dbl ? (w_expo_n >= 15'd2047) : (w_expo_n >= 15'd255);
      w_to_inf = (r_s1_rm == C_RNE) || (r_s1_rm == 3'd4) ||
                 ((r_s1_rm == C_RDN) && r_s1_sig) || ((r_s1_rm == C_RUP) && !r_s1_sig);
      w_zsig   = r_s1_diff ? (r_s1_rm == C_RDN) : r_s1_sig;
      w_inf    = r_s1_dbl ? {r_s1_sig, 11'h7FF, 52'd0} : {32'd0, r_s1_sig, 8'hFF, 23'd0};
      w_max    = r_s1_dbl ? {r_s1_sig, 11'h7FE, {52{1'b1}}} : {32'd0, r_s1_sig, 8'hFE, {23{1'b1}}};
      w_pk     = 64'd0;
      w_flags  = 5'd0;
      if (r_s1_snan) begin
         w_pk    = r_s1_dbl ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
         w_flags = 5'b10000;
      end else if (r_s1_qnan) begin
         w_pk    = r_s1_dbl ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
      end else if (r_s1_dbz) begin
         w_pk    = w_inf;
         w_flags = 5'b01000;
      end else if (r_s1_infs) begin
         w_pk    = w_inf;
      end else if (r_s1_zero) begin
         w_pk    = r_s1_dbl ? {w_zsig, 63'd0} : {32'd0, w_zsig, 31'd0};
      end else if (w_ovf) begin
         w_pk    = w_to_inf ? w_inf : w_max;
         w_flags = 5'b00101;
      end else begin
         w_pk = r_s1_dbl ? {r_s1_sig, w_expo_n[10:0], w_mant_n[51:0]}
                         : {32'd0, r_s1_sig, w_expo_n[7:0], w_mant_n[22:0]};
         if ((w_expo_n == 15'd0) && r_s1_inexact) begin
            w_flags = 5'b00011;
         end else if (r_s1_inexact) begin
            w_flags = 5'b00001;
         end
      end
      w_result = r_s1_dbl ? w_pk : {C_BOX, w_pk[31:0]};
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_s1_valid   <= 1'b0;
         r_s1_sig     <= 1'b0;
         r_s1_expo    <= 14'd0;
         r_s1_mant    <= 54'd0;
         r_s1_dbl     <= 1'b0;
         r_s1_rm      <= 3'd0;
         r_s1_inexact <= 1'b0;
         r_s1_snan    <= 1'b0;
         r_s1_qnan    <= 1'b0;
         r_s1_dbz     <= 1'b0;
         r_s1_infs    <= 1'b0;
         r_s1_zero    <= 1'b0;
         r_s1_diff    <= 1'b0;
         r_s2_valid   <= 1'b0;
         r_s2_result  <= 64'd0;
         r_s2_flags   <= 5'd0;
      end else if (fp_rnd_i_flush) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
      end else if (!fp_rnd_i_stall) begin
         r_s1_valid   <= fp_rnd_i_ready;
         r_s1_sig     <= fp_rnd_i_sig;
         r_s1_expo    <= fp_rnd_i_expo;
         r_s1_mant    <= w_mant_inc;
         r_s1_dbl     <= w_dbl;
         r_s1_rm      <= w_rm;
         r_s1_inexact <= w_inexact;
         r_s1_snan    <= fp_rnd_i_snan;
         r_s1_qnan    <= fp_rnd_i_qnan;
         r_s1_dbz     <= fp_rnd_i_dbz;
         r_s1_infs    <= fp_rnd_i_infs;
         r_s1_zero    <= fp_rnd_i_zero;
         r_s1_diff    <= fp_rnd_i_diff;
         r_s2_valid   <= r_s1_valid;
         r_s2_result  <= w_result;
         r_s2_flags   <= w_flags;
      end
   end

   assign fp_rnd_o_ready  = r_s2_valid;
   assign fp_rnd_o_result = r_s2_valid ? r_s2_result : 64'd0;
   assign fp_rnd_o_flags  = r_s2_valid ? r_s2_flags : 5'd0;

endmodule

// File: tb/tb_fp_rnd.sv
// tb/tb_fp_rnd.sv - directed vector table, pipeline sequences and random scoreboard for fp_rnd
module tb_fp_rnd;

`ifdef FP_RND_NANBOX_EN
   localparam logic [31:0] BOX = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] BOX = 32'h0000_0000;
`endif

   typedef struct {
      logic        sig;
      logic [13:0] expo;
      logic [53:0] mant;
      logic [1:0]  fmt;
      logic [2:0]  rm;
      logic [2:0]  grs;
      logic [5:0]  sp;     // {snan,qnan,dbz,infs,zero,diff}
      logic [63:0] res;
      logic [4:0]  flg;
   } vec_t;

   logic        clock;
   logic        reset;
   logic        i_sig;
   logic [13:0] i_expo;
   logic [53:0] i_mant;
   logic [1:0]  i_rema;
   logic [1:0]  i_fmt;
   logic [2:0]  i_rm;
   logic [2:0]  i_grs;
   logic        i_snan, i_qnan, i_dbz, i_infs, i_zero, i_diff;
   logic        i_ready, i_stall, i_flush;
   logic [63:0] o_result;
   logic [4:0]  o_flags;
   logic        o_ready;

   int tests = 0;
   int fails = 0;
   vec_t tbl[$];
   logic [68:0] sb[$];

   fp_rnd dut (
      .clock(clock), .reset(reset),
      .fp_rnd_i_sig(i_sig), .fp_rnd_i_expo(i_expo), .fp_rnd_i_mant(i_mant),
      .fp_rnd_i_rema(i_rema), .fp_rnd_i_fmt(i_fmt), .fp_rnd_i_rm(i_rm),
      .fp_rnd_i_grs(i_grs), .fp_rnd_i_snan(i_snan), .fp_rnd_i_qnan(i_qnan),
      .fp_rnd_i_dbz(i_dbz), .fp_rnd_i_infs(i_infs), .fp_rnd_i_zero(i_zero),
      .fp_rnd_i_diff(i_diff), .fp_rnd_i_ready(i_ready), .fp_rnd_i_stall(i_stall),
      .fp_rnd_i_flush(i_flush), .fp_rnd_o_result(o_result),
      .fp_rnd_o_flags(o_flags), .fp_rnd_o_ready(o_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic sig, input logic [13:0] expo, input logic [53:0] mant,
                               input logic [1:0] fmt, input logic [2:0] rm, input logic [2:0] grs,
                               input logic [5:0] sp, input logic [63:0] res, input logic [4:0] flg);
      vec_t v;
      v.sig = sig; v.expo = expo; v.mant = mant; v.fmt = fmt; v.rm = rm;
      v.grs = grs; v.sp = sp; v.res = res; v.flg = flg;
      return v;
   endfunction

   // Reference: rounding done on integer significands, packing by weighted sums.
   function automatic logic [68:0] ref_model(input vec_t v);
      logic              dbl, inx, up, zs;
      int                p, rmode;
      longint unsigned   one, m, e, emax, sb_w, res;
      logic [63:0]       r;
      logic [4:0]        fl;
      one   = 1;
      dbl   = (v.fmt == 2'd1);
      p     = dbl ? 53 : 24;
      emax  = dbl ? 2047 : 255;
      m     = 64'(v.mant) & ((one << p) - 1);
      e     = 64'(v.expo);
      rmode = (v.rm > 3'd4) ? 0 : int'(v.rm);
      inx   = (v.grs != 3'd0);
      case (rmode)
         0:       up = v.grs[2] && (v.grs[1] || v.grs[0] || m[0]);
         1:       up = 1'b0;
         2:       up = v.sig && inx;
         3:       up = !v.sig && inx;
         default: up = v.grs[2];
      endcase
      m = m + (up ? 1 : 0);
      if (m >= (one << p)) begin
         m = m / 2;
         e = e + 1;
      end
      if (e == 0 && m >= (one << (p - 1))) e = 1;
      sb_w = v.sig ? (dbl ? 64'h8000_0000_0000_0000 : 64'h8000_0000) : 64'd0;
      fl   = 5'd0;
      if (v.sp[5]) begin
         res = dbl ? 64'h7FF8_0000_0000_0000 : 64'h7FC0_0000; fl = 5'h10;
      end else if (v.sp[4]) begin
         res = dbl ? 64'h7FF8_0000_0000_0000 : 64'h7FC0_0000;
      end else if (v.sp[3]) begin
         res = sb_w | (dbl ? 64'h7FF0_0000_0000_0000 : 64'h7F80_0000); fl = 5'h08;
      end else if (v.sp[2]) begin
         res = sb_w | (dbl ? 64'h7FF0_0000_0000_0000 : 64'h7F80_0000);
      end else if (v.sp[1]) begin
         zs  = v.sp[0] ? (rmode == 2) : v.sig;
         res = zs ? (dbl ? 64'h8000_0000_0000_0000 : 64'h8000_0000) : 64'd0;
      end else if (e >= emax) begin
         fl = 5'h05;
         if (rmode == 0 || rmode == 4 || (rmode == 2 && v.sig) || (rmode == 3 && !v.sig))
            res = sb_w | (dbl ? 64'h7FF0_0000_0000_0000 : 64'h7F80_0000);
         else
            res = sb_w | (dbl ? 64'h7FEF_FFFF_FFFF_FFFF : 64'h7F7F_FFFF);
      end else begin
         res = sb_w + (e << (p - 1)) + (m % (one << (p - 1)));
         if (e == 0 && inx) fl = 5'h03;
         else if (inx)      fl = 5'h01;
      end
      r = res;
      if (!dbl) r[63:32] = BOX;
      return {fl, r};
   endfunction

   task automatic drive(input vec_t v, input logic rdy);
      i_sig = v.sig; i_expo = v.expo; i_mant = v.mant; i_fmt = v.fmt; i_rm = v.rm;
      i_grs = v.grs; i_rema = 2'($urandom);
      {i_snan, i_qnan, i_dbz, i_infs, i_zero, i_diff} = v.sp;
      i_ready = rdy;
   endtask

   task automatic chk_out(input string name, input vec_t v);
      chk({name, "_rdy"}, 69'(o_ready), 69'd1);
      chk({name, "_res"}, 69'(o_result), 69'(v.res));
      chk({name, "_flg"}, 69'(o_flags), 69'(v.flg));
   endtask

   task automatic chk_idle(input string name);
      chk(name, {o_flags, o_result}, 69'd0);
      chk({name, "_rdy"}, 69'(o_ready), 69'd0);
   endtask

   initial begin
      vec_t v;
      logic [68:0] prev, exp;
      logic        prev_rdy, acc, st, fl;

      tbl.push_back(mk(0, 1023, 54'h10000000000000, 1, 0, 3'b000, 6'b000000, 64'h3FF0000000000000, 5'h00));
      tbl.push_back(mk(0, 127, 54'hFFFFFF, 0, 0, 3'b100, 6'b000000, {BOX, 32'h40000000}, 5'h01));
      tbl.push_back(mk(0, 2047, 54'h1FFFFFFFFFFFFF, 1, 1, 3'b000, 6'b000000, 64'h7FEFFFFFFFFFFFFF, 5'h05));
      tbl.push_back(mk(0, 2047, 54'h1FFFFFFFFFFFFF, 1, 0, 3'b000, 6'b000000, 64'h7FF0000000000000, 5'h05));
      tbl.push_back(mk(0, 1023, 54'h10000000000000, 1, 0, 3'b000, 6'b100000, 64'h7FF8000000000000, 5'h10));
      tbl.push_back(mk(0, 0, 54'h0, 1, 2, 3'b000, 6'b000011, 64'h8000000000000000, 5'h00));
      tbl.push_back(mk(1, 0, 54'h0, 0, 0, 3'b000, 6'b010000, {BOX, 32'h7FC00000}, 5'h00));
      tbl.push_back(mk(1, 5, 54'h0, 0, 0, 3'b111, 6'b001000, {BOX, 32'hFF800000}, 5'h08));
      tbl.push_back(mk(0, 0, 54'h0, 1, 0, 3'b000, 6'b000100, 64'h7FF0000000000000, 5'h00));
      tbl.push_back(mk(1, 0, 54'h0, 0, 0, 3'b101, 6'b000010, {BOX, 32'h80000000}, 5'h00));
      tbl.push_back(mk(0, 0, 54'h0, 0, 0, 3'b000, 6'b101000, {BOX, 32'h7FC00000}, 5'h10));
      tbl.push_back(mk(0, 0, 54'h7FFFFF, 0, 0, 3'b100, 6'b000000, {BOX, 32'h00800000}, 5'h01));
      tbl.push_back(mk(0, 0, 54'h000001, 0, 1, 3'b001, 6'b000000, {BOX, 32'h00000001}, 5'h03));
      tbl.push_back(mk(0, 127, 54'h800000, 0, 0, 3'b100, 6'b000000, {BOX, 32'h3F800000}, 5'h01));
      tbl.push_back(mk(0, 127, 54'h800001, 0, 0, 3'b100, 6'b000000, {BOX, 32'h3F800002}, 5'h01));
      tbl.push_back(mk(1, 127, 54'h800000, 0, 3, 3'b001, 6'b000000, {BOX, 32'hBF800000}, 5'h01));
      tbl.push_back(mk(1, 127, 54'h800000, 0, 2, 3'b001, 6'b000000, {BOX, 32'hBF800001}, 5'h01));
      tbl.push_back(mk(0, 127, 54'h800000, 0, 4, 3'b100, 6'b000000, {BOX, 32'h3F800001}, 5'h01));
      tbl.push_back(mk(0, 127, 54'h800001, 0, 7, 3'b110, 6'b000000, {BOX, 32'h3F800002}, 5'h01));
      tbl.push_back(mk(0, 127, 54'h2A5A5A5A800000, 3, 0, 3'b000, 6'b000000, {BOX, 32'h3F800000}, 5'h00));
      tbl.push_back(mk(1, 254, 54'hFFFFFF, 0, 2, 3'b100, 6'b000000, {BOX, 32'hFF800000}, 5'h05));
      tbl.push_back(mk(1, 255, 54'h800000, 0, 3, 3'b000, 6'b000000, {BOX, 32'hFF7FFFFF}, 5'h05));
      tbl.push_back(mk(0, 2047, 54'h10000000000000, 1, 2, 3'b000, 6'b000000, 64'h7FEFFFFFFFFFFFFF, 5'h05));
      tbl.push_back(mk(1, 0, 54'h0, 1, 0, 3'b000, 6'b000011, 64'h0000000000000000, 5'h00));
      tbl.push_back(mk(0, 1023, 54'h1FFFFFFFFFFFFF, 1, 0, 3'b100, 6'b000000, 64'h4000000000000000, 5'h01));

      reset = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
      drive(tbl[0], 1'b1);
      repeat (3) @(posedge clock);
      #1 chk_idle("reset_state");
      @(negedge clock) reset = 1'b1; i_ready = 1'b0;

      // directed table, one op at a time with latency check
      for (int k = 0; k < tbl.size(); k++) begin
         @(negedge clock) drive(tbl[k], 1'b1);
         @(posedge clock); #1;
         chk($sformatf("lat1_v%0d", k), 69'(o_ready), 69'd0);
         @(negedge clock) i_ready = 1'b0;
         @(posedge clock); #1;
         chk_out($sformatf("vec%0d", k), tbl[k]);
      end
      @(negedge clock);
      @(posedge clock); #1 chk_idle("after_table");

      // three back-to-back ops
      for (int k = 0; k < 3; k++) begin
         @(negedge clock) drive(tbl[k + 1], 1'b1);
         @(posedge clock); #1;
         if (k > 0) chk_out($sformatf("b2b%0d", k - 1), tbl[k]);
      end
      @(negedge clock) i_ready = 1'b0;
      @(posedge clock); #1 chk_out("b2b2", tbl[3]);
      @(posedge clock); #1 chk_idle("b2b_end");

      // two-cycle stall mid-stream; input presented during stall is dropped
      @(negedge clock) drive(tbl[13], 1'b1);
      @(negedge clock) drive(tbl[14], 1'b1);
      @(posedge clock); #1 chk_out("stl_a0", tbl[13]);
      @(negedge clock) drive(tbl[15], 1'b1); i_stall = 1'b1;
      @(posedge clock); #1 chk_out("stl_h1", tbl[13]);
      @(posedge clock); #1 chk_out("stl_h2", tbl[13]);
      @(negedge clock) i_stall = 1'b0; i_ready = 1'b0;
      @(posedge clock); #1 chk_out("stl_b", tbl[14]);
      @(posedge clock); #1 chk_idle("stl_end");

      // flush one cycle after issue, and flush overriding stall
      @(negedge clock) drive(tbl[16], 1'b1);
      @(negedge clock) i_ready = 1'b1; i_flush = 1'b1; i_stall = 1'b1;
      @(posedge clock); #1 chk_idle("flush_1");
      @(negedge clock) i_flush = 1'b0; i_stall = 1'b0; i_ready = 1'b0;
      @(posedge clock); #1 chk_idle("flush_2");
      @(posedge clock); #1 chk_idle("flush_3");

      // reset with two ops in flight
      @(negedge clock) drive(tbl[17], 1'b1);
      @(negedge clock) drive(tbl[18], 1'b1);
      @(negedge clock) reset = 1'b0; i_ready = 1'b0;
      @(posedge clock); #1 chk_idle("rst_mid");
      @(negedge clock) reset = 1'b1;
      @(posedge clock); #1 chk_idle("rst_rel1");
      @(posedge clock); #1 chk_idle("rst_rel2");

      // random stream against the scoreboard
      for (int c = 0; c < 600; c++) begin
         @(negedge clock);
         v.sig  = 1'($urandom);
         v.fmt  = 2'($urandom_range(0, 3));
         v.expo = (v.fmt == 2'd1) ? 14'($urandom_range(0, 2048)) : 14'($urandom_range(0, 256));
         if ($urandom_range(0, 7) == 0) v.expo = (v.fmt == 2'd1) ? 14'd2046 : 14'd254;
         if ($urandom_range(0, 7) == 0) v.expo = 14'd0;
         v.mant = 54'({$urandom(), $urandom()});
         if ($urandom_range(0, 3) == 0) v.mant = {54{1'b1}};
         v.rm   = 3'($urandom_range(0, 7));
         v.grs  = 3'($urandom_range(0, 7));
         for (int b = 0; b < 6; b++) v.sp[b] = ($urandom_range(0, 15) == 0);
         st = ($urandom_range(0, 7) == 0);
         fl = ($urandom_range(0, 31) == 0);
         drive(v, ($urandom_range(0, 3) != 0));
         i_stall = st; i_flush = fl;
         acc = i_ready && !st && !fl;
         if (acc) sb.push_back(ref_model(v));
         prev = {o_flags, o_result}; prev_rdy = o_ready;
         @(posedge clock); #1;
         if (fl) begin
            chk("rnd_flush", {o_ready, o_flags, o_result}, 70'd0);
            sb.delete();
         end else if (st) begin
            chk("rnd_stall_hold", {o_ready, o_flags, o_result}, {prev_rdy, prev});
         end else if (o_ready) begin
            if (sb.size() == 0) begin
               chk("rnd_extra_out", 69'(o_ready), 69'd0);
            end else begin
               exp = sb.pop_front();
               chk("rnd_result", {o_flags, o_result}, exp);
            end
         end else begin
            chk("rnd_idle_zero", {o_flags, o_result}, 69'd0);
         end
      end

      // drain: every accepted op must have come out
      @(negedge clock) i_ready = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
      for (int d = 0; d < 3; d++) begin
         @(posedge clock); #1;
         if (o_ready && sb.size() > 0) begin
            exp = sb.pop_front();
            chk("drain_result", {o_flags, o_result}, exp);
         end
      end
      chk("drain_empty", 69'(sb.size()), 69'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
